line_dispatch_unit: RTL and testbench
=====================================

# line_dispatch_unit

Front end and collector for a bank of `line_solving_unit` instances. It accepts parsed machine lines on a valid/ready stream and issues each line to the lowest-indexed free solver with a one-cycle start pulse. It collects every solver's `result_ready` pulse and accumulates the saturating puzzle total. It raises `done` once the last line has been solved.

## Interface
- `NUM_LSU`, default 4: number of attached solvers.
- `MACHINE_COUNT`, default 10: machines per line.
- `MAX_BUTTON_COUNT`, default 13: maximum buttons per line.
- `BITS_PER_JOLTAGE`, default 9: width of one joltage target.
- `ANSWER_BIT_WIDTH`, default 16: width of a solver result.
- `TOTAL_BIT_WIDTH`, default 32: width of the accumulated total.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high. Shared with the solvers.
- `line_valid`  in  1  upstream line present.
- `line_ready`  out  1  dispatcher can accept a line this cycle.
- `line_last`  in  1  marks the final line of the puzzle.
- `line_button_count`  in  $clog2(MAX_BUTTON_COUNT+1)  buttons on this line.
- `line_buttons`  in  MACHINE_COUNT*MAX_BUTTON_COUNT  flattened button masks.
- `line_machines`  in  MACHINE_COUNT*BITS_PER_JOLTAGE  flattened targets.
- `lsu_start`  out  NUM_LSU  one-hot start pulse, bit i drives solver i.
- `lsu_button_count`, `lsu_buttons`, `lsu_machines`  out  as line_*  registered broadcast data to all solvers.
- `lsu_available`  in  NUM_LSU  solver `available` outputs.
- `lsu_result_ready`  in  NUM_LSU  solver result pulses.
- `lsu_results`  in  NUM_LSU*ANSWER_BIT_WIDTH  solver results; slice i belongs to solver i.
- `total`  out  TOTAL_BIT_WIDTH  sum of solved results.
- `lines_dispatched`, `lines_completed`  out  16 each  counters.
- `done`  out  1  level signal; all lines solved.
- `overflow`, `unsolved_seen`, `protocol_error`  out  1 each  sticky flags.

## Operation
- States: RUN, DRAIN, DONE.
  - RUN → DRAIN on accepting a line with `line_last=1`.
  - DRAIN → DONE when `busy==0` and no `lsu_result_ready` bit is high that cycle.
  - DONE holds until reset.
- `busy[NUM_LSU]` is an internal register.
  - A unit i is free when `lsu_available[i] && !busy[i]`.
  - `line_ready = (state==RUN) && (any unit free) && !start_pending`.
  - `start_pending` is high during the cycle in which `lsu_start` is asserted.
- On accept (`line_valid && line_ready`), the grant goes to the lowest free index i. At the next edge:
  - `lsu_*` data registers load the line;
  - `lsu_start <= 1<<i` and `busy[i] <= 1`;
  - `lines_dispatched` increments.
- `lsu_start` is high for exactly one cycle. The data registers hold until the next accept, so the solver latches stable data.
- Results:
  - Every high bit j of `lsu_result_ready` in a cycle is processed in that same cycle, in parallel.
  - A result equal to all-ones means "no solution": it sets `unsolved_seen` and adds 0.
  - Any other value is added to `total`.
  - The per-cycle sum is formed combinationally at TOTAL_BIT_WIDTH+1 bits.
  - If the sum exceeds all-ones, `total` saturates at all-ones and `overflow` is set.
  - For each valid pulse: `busy[j] <= 0` and `lines_completed` increments by the number of pulses.
- A pulse on a unit with `busy[j]=0` sets `protocol_error` and is otherwise ignored (no add, no count).
- A release and a new grant to the same unit in the same cycle are impossible: the release is registered first.

## Timing
- Reset values:
  - `lsu_start=0`; `lsu_*` data = 0; `total=0`; both counters = 0;
  - all flags = 0; `done=0`; `busy=0`; state = RUN.
  - Consequently `line_ready` goes high in the first cycle after reset if any `lsu_available` is high.
- Accept at edge k → `lsu_start` high in cycle k+1 → earliest next accept at edge k+2. Maximum throughput is 1 line per 2 cycles.
- A `lsu_result_ready` pulse in cycle r makes `total`/`busy` visible from cycle r+1. The freed unit is grantable from cycle r+1.
- `done` is asserted one cycle after the DRAIN exit condition is met.
- Reset mid-operation aborts everything; totals are lost, and the solvers reset with it.
- `line_valid` with `state!=RUN` is never accepted.

## Test plan
- Single line, NUM_LSU=4, all available. Solver 0 returns 7 after 50 cycles. Required: `lsu_start=0001` for one cycle; `total=7`; `lines_completed=1`; `done` high.
- Five lines back-to-back, all units available. Required: starts `0001, 0010, 0100, 1000`; `line_ready` low until the first result; the fifth line goes to the freed unit; `lines_dispatched=5`.
- Units 1 and 3 pulse in the same cycle with results 12 and 30, initial `total=100`. Required: `total=142` next cycle; `lines_completed` +2.
- Result 0xFFFF from a busy unit. Required: `unsolved_seen=1`; `total` unchanged; the unit is released.
- Preload `total` to 0xFFFFFFF0, then a result of 0x20. Required: `total=0xFFFFFFFF`; `overflow=1`.
- `lsu_result_ready[2]` pulses while unit 2 is idle. Required: `protocol_error=1`; counters and `total` unchanged. Then reset mid-DRAIN. Required: all outputs return to reset values.

Source files
------------

// File: rtl/line_dispatch_unit.sv
// line_dispatch_unit: issues parsed machine lines to the lowest-indexed free
// line_solving_unit, collects their result pulses into a saturating total and
// reports completion once the final line has been solved.
module line_dispatch_unit #(
  parameter int NUM_LSU          = 4,
  parameter int MACHINE_COUNT    = 10,
  parameter int MAX_BUTTON_COUNT = 13,
  parameter int BITS_PER_JOLTAGE = 9,
  parameter int ANSWER_BIT_WIDTH = 16,
  parameter int TOTAL_BIT_WIDTH  = 32
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        line_valid,
  output logic                                        line_ready,
  input  logic                                        line_last,
  input  logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]       line_button_count,
  input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]   line_buttons,
  input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]   line_machines,
  output logic [NUM_LSU-1:0]                          lsu_start,
  output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]       lsu_button_count,
  output logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]   lsu_buttons,
  output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]   lsu_machines,
  input  logic [NUM_LSU-1:0]                          lsu_available,
  input  logic [NUM_LSU-1:0]                          lsu_result_ready,
  input  logic [NUM_LSU*ANSWER_BIT_WIDTH-1:0]         lsu_results,
  output logic [TOTAL_BIT_WIDTH-1:0]                  total,
  output logic [15:0]                                 lines_dispatched,
  output logic [15:0]                                 lines_completed,
  output logic                                        done,
  output logic                                        overflow,
  output logic                                        unsolved_seen,
  output logic                                        protocol_error
);

  localparam int CNT_W = $clog2(NUM_LSU + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_LSU-1:0]         busy;
  logic [NUM_LSU-1:0]         free;
  logic [NUM_LSU-1:0]         grant;
  logic [NUM_LSU-1:0]         valid_pulse;
  logic [NUM_LSU-1:0]         stray_pulse;
  logic                       start_pending;
  logic                       accept;
  logic [TOTAL_BIT_WIDTH:0]   sum_d;
  logic                       unsolved_d;
  logic [CNT_W-1:0]           pulse_count;

  // A start pulse is still in flight while lsu_start is non-zero; blocking the
  // next accept for that cycle gives the solver one clean cycle to latch data.
  assign start_pending = |lsu_start;
  assign free          = lsu_available & ~busy;
  assign accept        = line_valid && line_ready;
  // Isolate the lowest set bit: lowest-index-wins priority among free units.
  assign grant         = free & (~free + NUM_LSU'(1));
  // Pulses from units we never started are flagged and otherwise dropped.
  assign valid_pulse   = lsu_result_ready & busy;
  assign stray_pulse   = lsu_result_ready & ~busy;

  // Combine every valid result of this cycle into one widened sum.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise a path
    // that skips an assignment would make synthesis infer a latch.
    sum_d       = {1'b0, total};
    unsolved_d  = 1'b0;
    pulse_count = '0;
    for (int j = 0; j < NUM_LSU; j++) begin
      if (valid_pulse[j]) begin
        pulse_count = pulse_count + CNT_W'(1);
        if (lsu_results[j*ANSWER_BIT_WIDTH +: ANSWER_BIT_WIDTH] == '1) begin
          unsolved_d = 1'b1;
        end else begin
          sum_d = sum_d + (TOTAL_BIT_WIDTH+1)'(lsu_results[j*ANSWER_BIT_WIDTH +: ANSWER_BIT_WIDTH]);
        end
      end
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next phase plus the phase-dependent handshake and completion outputs.
  always_comb begin
    state_d    = state_q;
    line_ready = 1'b0;
    done       = 1'b0;
    case (state_q)
      RUN: begin
        line_ready = (|free) && !start_pending;
        if (accept && line_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (busy == '0 && lsu_result_ready == '0) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Dispatch registers, unit occupancy, result accumulation and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_start        <= '0;
      lsu_button_count <= '0;
      lsu_buttons      <= '0;
      lsu_machines     <= '0;
      busy             <= '0;
      total            <= '0;
      lines_dispatched <= '0;
      lines_completed  <= '0;
      overflow         <= 1'b0;
      unsolved_seen    <= 1'b0;
      protocol_error   <= 1'b0;
    end else begin
      lsu_start <= accept ? grant : '0;
      // Grants only target idle units and releases only busy ones, so the
      // set and clear masks never overlap.
      busy      <= (busy & ~valid_pulse) | (accept ? grant : '0);
      if (accept) begin
        lsu_button_count <= line_button_count;
        lsu_buttons      <= line_buttons;
        lsu_machines     <= line_machines;
        lines_dispatched <= lines_dispatched + 16'd1;
      end
      lines_completed <= lines_completed + 16'(pulse_count);
      if (sum_d[TOTAL_BIT_WIDTH]) begin
        total    <= '1;
        overflow <= 1'b1;
      end else begin
        total <= sum_d[TOTAL_BIT_WIDTH-1:0];
      end
      if (unsolved_d)    unsolved_seen  <= 1'b1;
      if (|stray_pulse)  protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_dispatch_unit.sv
// tb_line_dispatch_unit: table-driven grant checks, directed corner-case
// sequences and a randomized run with emulated solvers, all compared against
// a behavioural model of the dispatcher kept in this bench.
module tb_line_dispatch_unit;

  localparam int N     = 4;
  localparam int MC    = 10;
  localparam int MBC   = 13;
  localparam int BPJ   = 9;
  localparam int AW    = 16;
  // A 20-bit total keeps the saturation boundary reachable in a short run.
  localparam int TW    = 20;
  localparam int BC_W  = $clog2(MBC + 1);
  localparam int BTN_W = MC * MBC;
  localparam int MCH_W = MC * BPJ;
  localparam longint TMAX = (longint'(1) << TW) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               line_valid;
  logic               line_ready;
  logic               line_last;
  logic [BC_W-1:0]    line_button_count;
  logic [BTN_W-1:0]   line_buttons;
  logic [MCH_W-1:0]   line_machines;
  logic [N-1:0]       lsu_start;
  logic [BC_W-1:0]    lsu_button_count;
  logic [BTN_W-1:0]   lsu_buttons;
  logic [MCH_W-1:0]   lsu_machines;
  logic [N-1:0]       lsu_available;
  logic [N-1:0]       lsu_result_ready;
  logic [N*AW-1:0]    lsu_results;
  logic [TW-1:0]      total;
  logic [15:0]        lines_dispatched;
  logic [15:0]        lines_completed;
  logic               done;
  logic               overflow;
  logic               unsolved_seen;
  logic               protocol_error;

  always #5 clk = ~clk;

  line_dispatch_unit #(
    .NUM_LSU(N), .MACHINE_COUNT(MC), .MAX_BUTTON_COUNT(MBC),
    .BITS_PER_JOLTAGE(BPJ), .ANSWER_BIT_WIDTH(AW), .TOTAL_BIT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .line_valid(line_valid), .line_ready(line_ready), .line_last(line_last),
    .line_button_count(line_button_count), .line_buttons(line_buttons),
    .line_machines(line_machines),
    .lsu_start(lsu_start), .lsu_button_count(lsu_button_count),
    .lsu_buttons(lsu_buttons), .lsu_machines(lsu_machines),
    .lsu_available(lsu_available), .lsu_result_ready(lsu_result_ready),
    .lsu_results(lsu_results),
    .total(total), .lines_dispatched(lines_dispatched),
    .lines_completed(lines_completed), .done(done), .overflow(overflow),
    .unsolved_seen(unsolved_seen), .protocol_error(protocol_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]     m_busy, m_start;
  longint           m_total;
  logic [15:0]      m_disp, m_comp;
  bit               m_ovf, m_uns, m_perr;
  int               m_phase;        // 0 accepting, 1 draining, 2 finished
  logic [BC_W-1:0]  m_bc;
  logic [BTN_W-1:0] m_btn;
  logic [MCH_W-1:0] m_mach;
  bit               m_acc;
  int               m_grant;

  task automatic model_reset();
    m_busy = '0; m_start = '0; m_total = 0; m_disp = '0; m_comp = '0;
    m_ovf = 0; m_uns = 0; m_perr = 0; m_phase = 0;
    m_bc = '0; m_btn = '0; m_mach = '0; m_acc = 0; m_grant = -1;
  endtask

  function automatic bit model_ready();
    logic [N-1:0] fr;
    fr = lsu_available & ~m_busy;
    return (m_phase == 0) && (fr != '0) && (m_start == '0);
  endfunction

  // Applies one clock edge worth of behaviour to the model.
  task automatic model_update();
    longint       sum;
    logic [N-1:0] nb;
    logic [AW-1:0] r;
    bit           drained;
    if (reset) begin
      model_reset();
      return;
    end
    m_acc   = line_valid && model_ready();
    drained = (m_busy == '0) && (lsu_result_ready == '0);
    sum     = m_total;
    nb      = m_busy;
    for (int j = 0; j < N; j++) begin
      if (lsu_result_ready[j]) begin
        if (m_busy[j]) begin
          m_comp++;
          nb[j] = 1'b0;
          r = lsu_results[j*AW +: AW];
          if (r == {AW{1'b1}}) m_uns = 1;
          else                 sum += r;
        end else begin
          m_perr = 1;
        end
      end
    end
    if (sum > TMAX) begin
      m_total = TMAX;
      m_ovf   = 1;
    end else begin
      m_total = sum;
    end
    m_start = '0;
    if (m_acc) begin
      m_grant = -1;
      for (int i = 0; i < N; i++) begin
        if (m_grant < 0 && lsu_available[i] && !m_busy[i]) m_grant = i;
      end
      m_start[m_grant] = 1'b1;
      nb[m_grant]      = 1'b1;
      m_bc = line_button_count; m_btn = line_buttons; m_mach = line_machines;
      m_disp++;
    end
    if (m_phase == 0 && m_acc && line_last) m_phase = 1;
    else if (m_phase == 1 && drained)       m_phase = 2;
    m_busy = nb;
  endtask

  task automatic check_all();
    check("line_ready", line_ready, model_ready());
    check("lsu_start", lsu_start, m_start);
    check("total", total, m_total);
    check("lines_dispatched", lines_dispatched, m_disp);
    check("lines_completed", lines_completed, m_comp);
    check("done", done, m_phase == 2);
    check("overflow", overflow, m_ovf);
    check("unsolved_seen", unsolved_seen, m_uns);
    check("protocol_error", protocol_error, m_perr);
    check("lsu_button_count", lsu_button_count, m_bc);
    check("lsu_buttons", lsu_buttons, m_btn);
    check("lsu_machines", lsu_machines, m_mach);
  endtask

  // ---------------- solver emulation ----------------
  bit            auto_sol = 0;
  logic [N-1:0]  sol_busy;
  int            sol_timer [N];
  logic [AW-1:0] sol_res   [N];

  task automatic solver_step(input logic [N-1:0] st);
    lsu_result_ready = '0;
    lsu_results      = '0;
    for (int i = 0; i < N; i++) begin
      if (sol_busy[i]) begin
        if (sol_timer[i] == 0) begin
          lsu_result_ready[i]     = 1'b1;
          lsu_results[i*AW +: AW] = sol_res[i];
          sol_busy[i]             = 1'b0;
        end else begin
          sol_timer[i]--;
        end
      end
      if (st[i]) begin
        sol_busy[i]  = 1'b1;
        sol_timer[i] = $urandom_range(1, 12);
        case ($urandom % 8)
          0:       sol_res[i] = '1;
          1:       sol_res[i] = AW'($urandom_range(40000, 65534));
          default: sol_res[i] = AW'($urandom_range(0, 4000));
        endcase
      end
      lsu_available[i] = !sol_busy[i] && ($urandom % 5 != 0);
    end
  endtask

  // One clock: compare mid-cycle, advance the model at the edge, drive after.
  task automatic cycle();
    logic [N-1:0] st;
    @(negedge clk);
    check_all();
    st = lsu_start;
    @(posedge clk);
    model_update();
    #1;
    if (auto_sol) solver_step(st);
  endtask

  task automatic new_line(input bit last);
    line_last         = last;
    line_button_count = BC_W'($urandom_range(0, MBC));
    for (int b = 0; b < BTN_W; b++) line_buttons[b]  = 1'($urandom % 2);
    for (int b = 0; b < MCH_W; b++) line_machines[b] = 1'($urandom % 2);
  endtask

  task automatic do_reset();
    reset = 1'b1; line_valid = 1'b0; line_last = 1'b0;
    lsu_result_ready = '0; lsu_results = '0; sol_busy = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic dispatch_one(input bit last, output int unit);
    bit got = 0;
    new_line(last);
    line_valid = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      cycle();
      got = m_acc;
    end
    line_valid = 1'b0;
    check("dispatch_accept", got, 1);
    unit = got ? m_grant : -1;
  endtask

  task automatic pulse(input logic [N-1:0] mask, input logic [N*AW-1:0] res);
    lsu_result_ready = mask;
    lsu_results      = res;
    cycle();
    lsu_result_ready = '0;
    lsu_results      = '0;
  endtask

  task automatic pulse1(input int u, input logic [AW-1:0] v);
    pulse(N'(1) << u, (N*AW)'(v) << (u * AW));
  endtask

  typedef struct {
    logic [N-1:0] avail;
    bit           ready;
    logic [N-1:0] start;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   u;
    int   sent;
    int   t;
    localparam int NL = 40;

    tbl[0] = '{4'b0000, 1'b0, 4'b0000};
    tbl[1] = '{4'b0001, 1'b1, 4'b0001};
    tbl[2] = '{4'b0110, 1'b1, 4'b0010};
    tbl[3] = '{4'b1000, 1'b1, 4'b1000};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001};
    tbl[5] = '{4'b1100, 1'b1, 4'b0100};

    lsu_available = '0;
    new_line(0);

    // Grant priority straight out of reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      lsu_available = tbl[i].avail;
      new_line(0);
      line_valid = 1'b1;
      #1;
      check("tbl_ready", line_ready, tbl[i].ready);
      cycle();
      line_valid = 1'b0;
      check("tbl_start", lsu_start, tbl[i].start);
    end

    // Single line solved by unit 0 after ~50 cycles.
    do_reset();
    lsu_available = 4'hF;
    dispatch_one(1, u);
    check("single_unit", u, 0);
    check("single_start", lsu_start, 4'b0001);
    cycle();
    check("single_start_once", lsu_start, 4'b0000);
    repeat (48) cycle();
    pulse1(0, 16'd7);
    check("single_total", total, 7);
    check("single_completed", lines_completed, 1);
    check("single_not_done_yet", done, 0);
    cycle();
    check("single_done", done, 1);

    // Five lines: four fill the bank, the fifth waits for a freed unit.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      dispatch_one(0, u);
      check("five_unit", u, k);
    end
    cycle();
    new_line(0);
    line_valid = 1'b1;
    repeat (8) begin
      cycle();
      check("five_ready_low", line_ready, 0);
    end
    line_valid = 1'b0;
    pulse1(2, 16'd5);
    check("five_ready_freed", line_ready, 1);
    dispatch_one(0, u);
    check("five_fifth_unit", u, 2);
    check("five_dispatched", lines_dispatched, 5);

    // Two simultaneous results on top of total=100, then a no-solution result.
    do_reset();
    for (int k = 0; k < 4; k++) dispatch_one(0, u);
    cycle();
    pulse1(0, 16'd100);
    check("par_pre_total", total, 100);
    pulse(4'b1010, ((N*AW)'(30) << (3*AW)) | ((N*AW)'(12) << AW));
    check("par_total", total, 142);
    check("par_completed", lines_completed, 3);
    pulse1(2, 16'hFFFF);
    check("unsolved_flag", unsolved_seen, 1);
    check("unsolved_total", total, 142);
    check("unsolved_completed", lines_completed, 4);
    cycle();
    for (int k = 0; k < 4; k++) begin
      dispatch_one(0, u);
      check("unsolved_regrant", u, k);
    end

    // Drive total up to all-ones minus 15, then push it past the top.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) dispatch_one(0, u);
      cycle();
      pulse(4'hF, {4{16'hFFFE}});
    end
    check("sat_step", total, 20'hFFFE0);
    dispatch_one(0, u);
    cycle();
    pulse1(u, 16'h10);
    check("sat_preload", total, 20'hFFFF0);
    check("sat_no_ovf", overflow, 0);
    dispatch_one(0, u);
    cycle();
    pulse1(u, 16'h20);
    check("sat_total", total, 20'hFFFFF);
    check("sat_ovf", overflow, 1);

    // Stray pulse on an idle unit, then reset while draining.
    do_reset();
    dispatch_one(0, u);
    cycle();
    pulse1(2, 16'd9);
    check("stray_flag", protocol_error, 1);
    check("stray_total", total, 0);
    check("stray_completed", lines_completed, 0);
    dispatch_one(1, u);
    check("stray_last_unit", u, 1);
    cycle();
    new_line(0);
    line_valid = 1'b1;
    repeat (3) cycle();
    check("drain_no_accept", lines_dispatched, 2);
    do_reset();
    check("rst_start", lsu_start, 0);
    check("rst_total", total, 0);
    check("rst_dispatched", lines_dispatched, 0);
    check("rst_completed", lines_completed, 0);
    check("rst_done", done, 0);
    check("rst_flags", {overflow, unsolved_seen, protocol_error}, 3'b000);
    check("rst_data", {lsu_button_count, lsu_buttons, lsu_machines}, 0);
    check("rst_ready", line_ready, 1);

    // Randomized run with emulated solvers.
    do_reset();
    auto_sol = 1;
    lsu_available = 4'hF;
    sent = 0;
    t = 0;
    while (sent < NL && t < 4000) begin
      t++;
      if (!line_valid && ($urandom % 4 != 0)) begin
        new_line(sent == NL - 1);
        line_valid = 1'b1;
      end
      cycle();
      if (m_acc) begin
        sent++;
        line_valid = 1'b0;
      end
    end
    line_valid = 1'b0;
    t = 0;
    while (m_phase != 2 && t < 2000) begin
      t++;
      cycle();
    end
    cycle();
    check("rand_done", done, 1);
    check("rand_dispatched", lines_dispatched, NL);
    check("rand_completed", lines_completed, NL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
